alu_result_packer: RTL and testbench
====================================

Name: alu_result_packer

Overview:
- Sits directly downstream of the ALU's shift, arithmetic and logic units.
- Captures each 16-bit ALU result when its valid flag is high, splits it into two bytes, and hands them one at a time to the UART TX FIFO over a valid/ready handshake.
- A one-entry pending buffer absorbs a result that arrives while the previous one is still being sent, so back-to-back ALU operations are not lost.

Parameters:
- DATA_W, 16, ALU result width; only 16 is supported.
- LSB_FIRST, 1, 1 = low byte sent first; 0 = high byte sent first.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- alu_out  input  DATA_W  ALU result; sampled only when alu_valid is high.
- alu_valid  input  1  result-valid flag from the ALU (for example the shift flag); each cycle high is one distinct result.
- tx_data  output  8  byte presented to the TX FIFO.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  FIFO can accept a byte; a transfer occurs on a rising edge where tx_valid and tx_ready are both high.
- busy  output  1  high when state is not IDLE.
- pend_full  output  1  pending buffer is occupied.
- overrun  output  1  one-cycle pulse: a result was dropped.

Behaviour:
- All outputs are registered.
- Reset (RST low, asynchronous):
  - state = IDLE.
  - hold, pending, tx_data = 0.
  - tx_valid, busy, pend_full, overrun = 0.
  - Reset in the middle of a transfer discards both stored words; no partial byte is emitted after release.
- States: IDLE, BYTE0, BYTE1.
  - BYTE0 presents the first byte of hold: hold[7:0] if LSB_FIRST, else hold[15:8].
  - BYTE1 presents the other byte.
  - tx_valid = 1 in BYTE0 and BYTE1.
- IDLE:
  - alu_valid = 1 at an edge: hold <= alu_out and state <= BYTE0.
  - tx_valid and the first byte appear on the following cycle, so latency from alu_valid to first tx_valid is 1 cycle.
- BYTE0:
  - Transfer (tx_valid & tx_ready) moves to BYTE1.
  - Otherwise stays in BYTE0.
- BYTE1:
  - On transfer with pend_full = 1: hold <= pending and state <= BYTE0.
    - pending <= alu_out if alu_valid is high in the same cycle; otherwise pending is cleared.
    - No overrun in this case.
  - On transfer with pend_full = 0 and alu_valid = 1: hold <= alu_out and state <= BYTE0. This is the zero-bubble path.
  - On transfer with neither: state <= IDLE.
- alu_valid while in BYTE0 or BYTE1, excluding the BYTE1-transfer edge:
  - If pend_full = 0: pending <= alu_out and pend_full <= 1.
  - Else: the new result is dropped, overrun pulses high for exactly 1 cycle, and hold/pending are unchanged.
- Stability:
  - While tx_valid = 1 and tx_ready = 0, tx_data and state are held.
  - tx_valid never drops without a transfer, except on reset.
- Throughput: one byte per cycle when tx_ready is held high, so one result every 2 cycles sustained.
- tx_ready is ignored in IDLE.
- The value of alu_out is ignored when alu_valid = 0.

Test Plan:
- Single word: reset, then alu_valid = 1 with alu_out = 0xA55A for 1 cycle, tx_ready = 1 → next cycle tx_data = 0x5A; following cycle tx_data = 0xA5; then busy = 0 and tx_valid = 0.
- Backpressure: alu_out = 0x1234 with tx_ready = 0 for 5 cycles → tx_data held at 0x34 with tx_valid = 1. Release tx_ready → 0x34 then 0x12, each transferred exactly once.
- Pending and overrun: tx_ready = 0; send results 0x1111, 0x2222, 0x3333 on consecutive cycles → pend_full = 1 after 0x2222; overrun pulses once for 0x3333. With tx_ready = 1 the output is 0x11, 0x11, 0x22, 0x22, and 0x33 is never seen.
- Zero bubble: tx_ready = 1; alu_valid pulses every 2 cycles with 0x0001, 0x0002, 0x0003 → continuous tx_valid, bytes 01 00 02 00 03 00, no overrun.
- LSB_FIRST = 0: alu_out = 0xBEEF → 0xBE then 0xEF.
- Reset mid-transfer: assert RST low while in BYTE1 with pend_full = 1 → all outputs 0 immediately. After release with tx_ready = 1 and no alu_valid, no bytes are emitted.

Source files
------------

// File: rtl/alu_result_packer.sv
// alu_result_packer
// Captures 16-bit ALU results, splits each into two bytes and streams them
// to the UART TX FIFO over valid/ready. A one-entry pending buffer absorbs
// a result that arrives while the previous one is still being sent.
module alu_result_packer #(
  parameter int DATA_W    = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              pend_full,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] hold, hold_nx;
  logic [DATA_W-1:0] pending, pending_nx;
  logic              pend_full_nx;
  logic              overrun_nx;
  logic [7:0]        tx_data_nx;
  logic              xfer;

  // Byte order within a word; only 16-bit results are supported.
  function automatic logic [7:0] first_byte(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [7:0] second_byte(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  assign xfer = tx_valid & tx_ready;

  // Next-state, storage and output computation; outputs are derived from the
  // next state so every port comes straight from a flop.
  always_comb begin
    state_nx     = state;
    hold_nx      = hold;
    pending_nx   = pending;
    pend_full_nx = pend_full;
    overrun_nx   = 1'b0;
    tx_data_nx   = 8'h00;

    case (state)
      IDLE: begin
        if (alu_valid) begin
          hold_nx  = alu_out;
          state_nx = BYTE0;
        end
      end

      BYTE0: begin
        if (xfer) begin
          state_nx = BYTE1;
        end
        if (alu_valid) begin
          if (!pend_full) begin
            pending_nx   = alu_out;
            pend_full_nx = 1'b1;
          end else begin
            overrun_nx = 1'b1;
          end
        end
      end

      BYTE1: begin
        if (xfer) begin
          if (pend_full) begin
            hold_nx  = pending;
            state_nx = BYTE0;
            if (alu_valid) begin
              pending_nx = alu_out;
            end else begin
              pending_nx   = '0;
              pend_full_nx = 1'b0;
            end
          end else if (alu_valid) begin
            hold_nx  = alu_out;
            state_nx = BYTE0;
          end else begin
            state_nx = IDLE;
          end
        end else if (alu_valid) begin
          if (!pend_full) begin
            pending_nx   = alu_out;
            pend_full_nx = 1'b1;
          end else begin
            overrun_nx = 1'b1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    case (state_nx)
      BYTE0:   tx_data_nx = first_byte(hold_nx);
      BYTE1:   tx_data_nx = second_byte(hold_nx);
      default: tx_data_nx = 8'h00;
    endcase
  end

  // State, word storage and registered outputs; reset discards both words.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      hold      <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      overrun   <= 1'b0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      pending   <= pending_nx;
      pend_full <= pend_full_nx;
      overrun   <= overrun_nx;
      tx_data   <= tx_data_nx;
      tx_valid  <= (state_nx != IDLE);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// tb_alu_result_packer
// Table-driven directed vectors against the low-byte-first packer, plus
// hand-written sequences for high-byte-first ordering and mid-transfer reset.
module tb_alu_result_packer;

  logic        clk;
  logic        RST;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic        tx_ready;

  logic [7:0]  tx_data_l, tx_data_m;
  logic        tx_valid_l, tx_valid_m;
  logic        busy_l, busy_m;
  logic        pend_full_l, pend_full_m;
  logic        overrun_l, overrun_m;

  int vec_count;
  int miscompares;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic [7:0]  e_data;
    logic        e_valid;
    logic        e_busy;
    logic        e_pf;
    logic        e_ov;
  } vec_t;

  vec_t vq[$];

  alu_result_packer #(.DATA_W(16), .LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .RST       (RST),
    .alu_out   (alu_out),
    .alu_valid (alu_valid),
    .tx_data   (tx_data_l),
    .tx_valid  (tx_valid_l),
    .tx_ready  (tx_ready),
    .busy      (busy_l),
    .pend_full (pend_full_l),
    .overrun   (overrun_l)
  );

  alu_result_packer #(.DATA_W(16), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .RST       (RST),
    .alu_out   (alu_out),
    .alu_valid (alu_valid),
    .tx_data   (tx_data_m),
    .tx_valid  (tx_valid_m),
    .tx_ready  (tx_ready),
    .busy      (busy_m),
    .pend_full (pend_full_m),
    .overrun   (overrun_m)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic [7:0] ed, input logic ev, input logic eb,
                              input logic ep, input logic eo);
    vec_t t;
    t.v = v; t.d = d; t.r = r;
    t.e_data = ed; t.e_valid = ev; t.e_busy = eb; t.e_pf = ep; t.e_ov = eo;
    return t;
  endfunction

  // Drive inputs on the falling edge, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    alu_valid = v;
    alu_out   = d;
    tx_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ed, input logic ev,
                             input logic eb, input logic ep, input logic eo);
    vec_count++;
    if (tx_data_l !== ed || tx_valid_l !== ev || busy_l !== eb ||
        pend_full_l !== ep || overrun_l !== eo) begin
      miscompares++;
      $display("[TB] FAIL %s: got data=%h valid=%b busy=%b pf=%b ov=%b, want data=%h valid=%b busy=%b pf=%b ov=%b",
               name, tx_data_l, tx_valid_l, busy_l, pend_full_l, overrun_l,
               ed, ev, eb, ep, eo);
    end
  endtask

  task automatic checkMsb(input string name, input logic [7:0] ed, input logic ev,
                          input logic eb);
    vec_count++;
    if (tx_data_m !== ed || tx_valid_m !== ev || busy_m !== eb) begin
      miscompares++;
      $display("[TB] FAIL %s: got data=%h valid=%b busy=%b, want data=%h valid=%b busy=%b",
               name, tx_data_m, tx_valid_m, busy_m, ed, ev, eb);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    RST         = 1'b0;
    alu_valid   = 1'b0;
    alu_out     = 16'h0000;
    tx_ready    = 1'b0;

    // Single word A55A
    vq.push_back(mk(1, 16'hA55A, 1, 8'h5A, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'hA5, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 16'hFFFF, 1, 8'h00, 0, 0, 0, 0));
    // Backpressure 1234, held 5 cycles
    vq.push_back(mk(1, 16'h1234, 0, 8'h34, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 16'h0000, 0, 8'h34, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h12, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    // Pending and overrun
    vq.push_back(mk(1, 16'h1111, 0, 8'h11, 1, 1, 0, 0));
    vq.push_back(mk(1, 16'h2222, 0, 8'h11, 1, 1, 1, 0));
    vq.push_back(mk(1, 16'h3333, 0, 8'h11, 1, 1, 1, 1));
    vq.push_back(mk(0, 16'h0000, 0, 8'h11, 1, 1, 1, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h11, 1, 1, 1, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h22, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h22, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    // Zero bubble 0001, 0002, 0003
    vq.push_back(mk(1, 16'h0001, 1, 8'h01, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 1, 1, 0, 0));
    vq.push_back(mk(1, 16'h0002, 1, 8'h02, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 1, 1, 0, 0));
    vq.push_back(mk(1, 16'h0003, 1, 8'h03, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));
    // Pending fill during BYTE1, then refill on the BYTE1 transfer edge
    vq.push_back(mk(1, 16'h5678, 0, 8'h78, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h56, 1, 1, 0, 0));
    vq.push_back(mk(1, 16'h9ABC, 0, 8'h56, 1, 1, 1, 0));
    vq.push_back(mk(1, 16'hDEF0, 1, 8'hBC, 1, 1, 1, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h9A, 1, 1, 1, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'hF0, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'hDE, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0000, 1, 8'h00, 0, 0, 0, 0));

    doReset();
    #1;
    checkOutput("reset_state", 8'h00, 0, 0, 0, 0);

    foreach (vq[i]) begin
      applyStimulus(vq[i].v, vq[i].d, vq[i].r);
      checkOutput($sformatf("vec%0d", i), vq[i].e_data, vq[i].e_valid,
                  vq[i].e_busy, vq[i].e_pf, vq[i].e_ov);
    end

    // High-byte-first ordering: BEEF
    applyStimulus(1, 16'hBEEF, 1);
    checkMsb("msb_first_byte", 8'hBE, 1, 1);
    checkOutput("lsb_beef_byte0", 8'hEF, 1, 1, 0, 0);
    applyStimulus(0, 16'h0000, 1);
    checkMsb("msb_second_byte", 8'hEF, 1, 1);
    checkOutput("lsb_beef_byte1", 8'hBE, 1, 1, 0, 0);
    applyStimulus(0, 16'h0000, 1);
    checkMsb("msb_idle", 8'h00, 0, 0);

    // Reset in BYTE1 with the pending buffer occupied
    applyStimulus(1, 16'h4444, 0);
    applyStimulus(1, 16'h5555, 0);
    applyStimulus(0, 16'h0000, 1);
    checkOutput("pre_reset_byte1", 8'h44, 1, 1, 1, 0);
    @(negedge clk);
    RST = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 0, 0, 0, 0);
    checkMsb("async_reset_msb", 8'h00, 0, 0);
    @(negedge clk);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 16'hFFFF, 1);
      checkOutput($sformatf("post_reset_quiet%0d", i), 8'h00, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
